// File: rtl/vrased_mon_pkg.sv
// Shared definitions for the VRASED region monitor: FSM encoding,
// cause/mode bit positions and the non-wrapping address range test.
package vrased_mon_pkg;

  // Monitor FSM encoding
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Bit positions inside the captured cause vector
  localparam int CAUSE_CPU  = 0;
  localparam int CAUSE_DMA  = 1;
  localparam int CAUSE_ATOM = 2;
  localparam int CAUSE_IRQ  = 3;

  // Bit positions inside a region mode field
  localparam int MODE_CPU_SMEM_ONLY = 0;
  localparam int MODE_DMA_DENY      = 1;

  // True when base <= a < base+size, evaluated in 17 bits so the upper
  // bound never wraps; a zero size can never match.
  function automatic logic in_range(input logic [15:0] a,
                                    input logic [15:0] base,
                                    input logic [15:0] size);
    logic [16:0] a_ext;
    logic [16:0] lo;
    logic [16:0] hi;
    a_ext = {1'b0, a};
    lo    = {1'b0, base};
    hi    = lo + {1'b0, size};
    return (a_ext >= lo) && (a_ext < hi);
  endfunction

endpackage

// File: rtl/vrased_region_chk.sv
// Per-region access checker: flags CPU accesses made from outside SMEM to a
// SMEM-only region and any DMA access to a DMA-denied region.
module vrased_region_chk
  import vrased_mon_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000,
  parameter logic [1:0]  MODE = 2'b00
) (
  input  logic        i_cpu_acc,
  input  logic [15:0] i_data_addr,
  input  logic        i_dma_en,
  input  logic [15:0] i_dma_addr,
  input  logic        i_in_smem,
  output logic        o_cpu_viol,
  output logic        o_dma_viol
);

  logic w_cpu_hit;
  logic w_dma_hit;

  assign w_cpu_hit = in_range(i_data_addr, BASE, SIZE);
  assign w_dma_hit = in_range(i_dma_addr, BASE, SIZE);

  assign o_cpu_viol = i_cpu_acc & w_cpu_hit & MODE[MODE_CPU_SMEM_ONLY] & ~i_in_smem;
  assign o_dma_viol = i_dma_en & w_dma_hit & MODE[MODE_DMA_DENY];

endmodule

// File: rtl/vrased_region_mon.sv
// VRASED hardware monitor: checks NREG protected regions against CPU and DMA
// accesses, enforces SMEM atomicity, and on a violation drives a reset that
// lasts at least HOLD_CYCLES+1 cycles and is released only once the pc
// reaches the reset handler. A sticky cause/region record survives the
// violation reset for software to inspect.
module vrased_region_mon
  import vrased_mon_pkg::*;
#(
  parameter int                   NREG          = 4,
  parameter logic [NREG*16-1:0]   REG_BASE      = '0,
  parameter logic [NREG*16-1:0]   REG_SIZE      = '0,
  parameter logic [NREG*2-1:0]    REG_MODE      = '0,
  parameter logic [15:0]          SMEM_BASE     = 16'hA000,
  parameter logic [15:0]          SMEM_SIZE     = 16'h4000,
  parameter logic [15:0]          RESET_HANDLER = 16'h0000,
  parameter int                   HOLD_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic        dma_en,
  input  logic [15:0] dma_addr,
  input  logic        irq,
  output logic        reset,
  output logic [3:0]  viol_cause,
  output logic [2:0]  viol_region
);

  localparam int          CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  // Only legal way out of SMEM is falling through from its last word
  localparam logic [15:0] EXIT_PC   = SMEM_BASE + SMEM_SIZE - 16'd2;

  logic [1:0]      r_state;
  logic            r_reset;
  logic [3:0]      r_cause;
  logic [2:0]      r_region;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_prev_pc;
  logic            r_prev_in_smem;

  logic            w_cpu_acc;
  logic            w_in_smem;
  logic            w_dma_smem;
  logic [NREG-1:0] w_cpu_viol;
  logic [NREG-1:0] w_dma_viol;
  logic [NREG-1:0] w_reg_viol;
  logic [2:0]      w_region;
  logic            w_atom_entry;
  logic            w_atom_exit;
  logic [3:0]      w_cause;
  logic            w_any_viol;

  assign w_cpu_acc  = data_en | data_wr;
  assign w_in_smem  = in_range(pc, SMEM_BASE, SMEM_SIZE);
  assign w_dma_smem = dma_en & in_range(dma_addr, SMEM_BASE, SMEM_SIZE);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      vrased_region_chk #(
        .BASE (REG_BASE[16*gi +: 16]),
        .SIZE (REG_SIZE[16*gi +: 16]),
        .MODE (REG_MODE[2*gi +: 2])
      ) u_chk (
        .i_cpu_acc   (w_cpu_acc),
        .i_data_addr (data_addr),
        .i_dma_en    (dma_en),
        .i_dma_addr  (dma_addr),
        .i_in_smem   (w_in_smem),
        .o_cpu_viol  (w_cpu_viol[gi]),
        .o_dma_viol  (w_dma_viol[gi])
      );
    end
  endgenerate

  assign w_reg_viol = w_cpu_viol | w_dma_viol;

  // Lowest-index violating region wins; 0 when no region is involved
  always_comb begin
    w_region = 3'd0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (w_reg_viol[k]) begin
        w_region = 3'(k);
      end
    end
  end

  // Entering SMEM anywhere but its first word, or leaving from anywhere but its last
  assign w_atom_entry = ~r_prev_in_smem & w_in_smem & (pc != SMEM_BASE);
  assign w_atom_exit  = r_prev_in_smem & ~w_in_smem & (r_prev_pc != EXIT_PC);

  always_comb begin
    w_cause             = 4'd0;
    w_cause[CAUSE_CPU]  = |w_cpu_viol;
    w_cause[CAUSE_DMA]  = (|w_dma_viol) | w_dma_smem;
    w_cause[CAUSE_ATOM] = w_atom_entry | w_atom_exit;
    w_cause[CAUSE_IRQ]  = irq & w_in_smem;
  end

  assign w_any_viol = |w_cause;

  // Track the previous pc while running; forget it while the core is held in reset
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_prev_pc      <= 16'h0000;
      r_prev_in_smem <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_prev_pc      <= pc;
      r_prev_in_smem <= w_in_smem;
    end else begin
      r_prev_pc      <= 16'h0000;
      r_prev_in_smem <= 1'b0;
    end
  end

  // RUN/HOLD/WAIT sequencing of the violation reset and its minimum-length counter
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= ST_RUN;
      r_reset <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_any_viol) begin
            r_state <= ST_HOLD;
            r_reset <= 1'b1;
            r_cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          r_reset <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (pc == RESET_HANDLER) begin
            r_state <= ST_RUN;
            r_reset <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_reset <= 1'b0;
        end
      endcase
    end
  end

  // Sticky violation record, captured only on the RUN->HOLD transition
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_cause  <= 4'd0;
      r_region <= 3'd0;
    end else if ((r_state == ST_RUN) && w_any_viol) begin
      r_cause  <= w_cause;
      r_region <= w_region;
    end
  end

  assign reset       = r_reset;
  assign viol_cause  = r_cause;
  assign viol_region = r_region;

endmodule

// File: tb/tb_vrased_region_mon.sv
// Self-checking bench for vrased_region_mon: a table of single-violation
// vectors followed by hand-written multi-cycle sequences (hold length,
// wait-for-handler release, sticky record, asynchronous puc_rst).
module tb_vrased_region_mon;

  logic        clk;
  logic        puc_rst;
  logic [15:0] pc;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic        dma_en;
  logic [15:0] dma_addr;
  logic        irq;
  logic        reset;
  logic [3:0]  viol_cause;
  logic [2:0]  viol_region;

  int n_checks;
  int n_errors;

  // R0 0x6A00/0x40 mode 11, R1 0x7000/0x100 mode 11,
  // R2 0x8000/0x100 mode 01 (CPU only), R3 size 0 (disabled)
  vrased_region_mon #(
    .NREG          (4),
    .REG_BASE      ({16'h0000, 16'h8000, 16'h7000, 16'h6A00}),
    .REG_SIZE      ({16'h0000, 16'h0100, 16'h0100, 16'h0040}),
    .REG_MODE      ({2'b11, 2'b01, 2'b11, 2'b11}),
    .SMEM_BASE     (16'hA000),
    .SMEM_SIZE     (16'h4000),
    .RESET_HANDLER (16'h0000),
    .HOLD_CYCLES   (8)
  ) dut (
    .clk         (clk),
    .puc_rst     (puc_rst),
    .pc          (pc),
    .data_en     (data_en),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .dma_en      (dma_en),
    .dma_addr    (dma_addr),
    .irq         (irq),
    .reset       (reset),
    .viol_cause  (viol_cause),
    .viol_region (viol_region)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc_prev;
    logic [15:0] pc_now;
    logic        den;
    logic        dwr;
    logic [15:0] daddr;
    logic        men;
    logic [15:0] maddr;
    logic        irq_v;
    logic        exp_rst;
    logic [3:0]  exp_cause;
    logic [2:0]  exp_reg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic [15:0] pp, input logic [15:0] p,
                     input logic de, input logic dw, input logic [15:0] da,
                     input logic me, input logic [15:0] ma, input logic iq,
                     input logic er, input logic [3:0] ec, input logic [2:0] eg);
    vec_t v;
    v.name = n; v.pc_prev = pp; v.pc_now = p; v.den = de; v.dwr = dw; v.daddr = da;
    v.men = me; v.maddr = ma; v.irq_v = iq; v.exp_rst = er; v.exp_cause = ec; v.exp_reg = eg;
    vq.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic idle();
    data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0000;
    dma_en = 1'b0; dma_addr = 16'h0000; irq = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    pc = 16'h0000;
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    pc = 16'h0000;
    puc_rst = 1'b1;
    #12;
    chk("rst_reset", {31'd0, reset}, 32'd0);
    chk("rst_cause", {28'd0, viol_cause}, 32'd0);
    chk("rst_region", {29'd0, viol_region}, 32'd0);
    tick();
    puc_rst = 1'b0;

    //   name          pc_prev   pc        den  dwr  daddr     dma  dmaddr    irq  rst  cause    reg
    add("cpu_r0",      16'hE000, 16'hE000, 1, 0, 16'h6A10, 0, 16'h0000, 0, 1, 4'b0001, 3'd0);
    add("cpu_in_smem", 16'hA100, 16'hA100, 1, 0, 16'h6A10, 0, 16'h0000, 0, 0, 4'b0000, 3'd0);
    add("cpu_noacc",   16'hE000, 16'hE000, 0, 0, 16'h6A10, 0, 16'h0000, 0, 0, 4'b0000, 3'd0);
    add("dma_r0",      16'hA100, 16'hA100, 0, 0, 16'h0000, 1, 16'h6A00, 0, 1, 4'b0010, 3'd0);
    add("dma_r2_cpu",  16'hE000, 16'hE000, 0, 0, 16'h0000, 1, 16'h8010, 0, 0, 4'b0000, 3'd0);
    add("cpu_r2_wr",   16'hE000, 16'hE000, 0, 1, 16'h80FF, 0, 16'h0000, 0, 1, 4'b0001, 3'd2);
    add("bound_top",   16'hE000, 16'hE000, 1, 0, 16'h6A40, 1, 16'h6A40, 0, 0, 4'b0000, 3'd0);
    add("bound_low",   16'hE000, 16'hE000, 1, 0, 16'h69FF, 1, 16'h69FF, 0, 0, 4'b0000, 3'd0);
    add("dma_smem",    16'hE000, 16'hE000, 0, 0, 16'h0000, 1, 16'hA000, 0, 1, 4'b0010, 3'd0);
    add("r3_disabled", 16'hE000, 16'hE000, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 4'b0000, 3'd0);
    add("entry_bad",   16'h4000, 16'hA002, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 4'b0100, 3'd0);
    add("entry_ok",    16'h4000, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000, 3'd0);
    add("exit_ok",     16'hDFFE, 16'hE000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000, 3'd0);
    add("exit_multi",  16'hA100, 16'hE000, 1, 0, 16'h7010, 1, 16'h6A00, 0, 1, 4'b0111, 3'd0);
    add("entry_multi", 16'h4000, 16'hA200, 0, 0, 16'h0000, 1, 16'h7080, 1, 1, 4'b1110, 3'd1);
    add("irq_outside", 16'hE000, 16'hE000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 4'b0000, 3'd0);
    add("irq_smem",    16'hA100, 16'hA200, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 4'b1000, 3'd0);

    foreach (vq[i]) begin
      reset_dut();
      // Step into SMEM via its base so the lead-in itself is legal
      pc = (vq[i].pc_prev >= 16'hA000 && vq[i].pc_prev < 16'hE000) ? 16'hA000 : vq[i].pc_prev;
      tick();
      pc = vq[i].pc_prev;
      tick();
      pc = vq[i].pc_now;
      data_en = vq[i].den; data_wr = vq[i].dwr; data_addr = vq[i].daddr;
      dma_en = vq[i].men; dma_addr = vq[i].maddr; irq = vq[i].irq_v;
      tick();
      idle();
      chk({vq[i].name, "_reset"}, {31'd0, reset}, {31'd0, vq[i].exp_rst});
      chk({vq[i].name, "_cause"}, {28'd0, viol_cause}, {28'd0, vq[i].exp_cause});
      chk({vq[i].name, "_region"}, {29'd0, viol_region}, {29'd0, vq[i].exp_reg});
      $display("vec %0d %s: reset=%0b cause=%b region=%0d", i, vq[i].name, reset, viol_cause, viol_region);
    end

    // Minimum hold with pc already at the handler: reset high exactly 9 cycles
    begin
      int cnt;
      reset_dut();
      pc = 16'hE000;
      tick();
      data_en = 1'b1; data_addr = 16'h6A10;
      tick();
      idle();
      pc = 16'h0000;
      cnt = 0;
      while (reset && cnt < 50) begin
        cnt++;
        tick();
      end
      chk("hold_len", cnt, 32'd9);
      chk("hold_cause_kept", {28'd0, viol_cause}, 32'h1);
      $display("seq hold_len: reset high %0d cycles", cnt);
    end

    // Held in WAIT while pc is away from the handler; later violations ignored
    reset_dut();
    pc = 16'hE000;
    tick();
    dma_en = 1'b1; dma_addr = 16'h7000;
    tick();
    idle();
    chk("wait_first_cause", {28'd0, viol_cause}, 32'h2);
    chk("wait_first_region", {29'd0, viol_region}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k >= 12) begin
        data_en = 1'b1; data_addr = 16'h6A10; irq = 1'b1;
      end
      tick();
    end
    chk("wait_still_reset", {31'd0, reset}, 32'd1);
    chk("wait_cause_kept", {28'd0, viol_cause}, 32'h2);
    chk("wait_region_kept", {29'd0, viol_region}, 32'd1);
    idle();
    pc = 16'h0000;
    tick();
    chk("release_reset", {31'd0, reset}, 32'd0);
    chk("release_cause_sticky", {28'd0, viol_cause}, 32'h2);
    chk("release_region_sticky", {29'd0, viol_region}, 32'd1);
    $display("seq wait_release: reset=%0b cause=%b region=%0d", reset, viol_cause, viol_region);
    tick();
    chk("run_stays_low", {31'd0, reset}, 32'd0);
    data_en = 1'b1; data_addr = 16'h6A10;
    tick();
    idle();
    chk("recapture_cause", {28'd0, viol_cause}, 32'h1);
    chk("recapture_region", {29'd0, viol_region}, 32'd0);
    chk("recapture_reset", {31'd0, reset}, 32'd1);
    $display("seq recapture: reset=%0b cause=%b region=%0d", reset, viol_cause, viol_region);

    // Asynchronous puc_rst in the middle of HOLD
    tick();
    tick();
    #2;
    puc_rst = 1'b1;
    #1;
    chk("async_reset", {31'd0, reset}, 32'd0);
    chk("async_cause", {28'd0, viol_cause}, 32'd0);
    chk("async_region", {29'd0, viol_region}, 32'd0);
    $display("seq async_rst: reset=%0b cause=%b region=%0d", reset, viol_cause, viol_region);
    puc_rst = 1'b0;
    pc = 16'hE000;
    tick();
    chk("after_async_run", {31'd0, reset}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
